sensor_block_store: RTL and testbench

- Per-sensor block buffer; the responder side of the block-request interface used by the pulse identification logic.
- Captures decoded sensor words (17-bit data) from the sensor decoder, stamping each with sys_ts, as 41-bit blocks.
- Publishes how many blocks are available and serves random-access block requests by 1-based block number with a data_ready handshake.
- One instance per photodiode (three in the tracker top level).

---
 rtl/sensor_block_store.sv | 191 +++++++++++++++++++
 tb/tb_sensor_block_store.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_block_store.sv
// rtl/sensor_block_store.sv - per-sensor 41-bit block buffer serving random-access block requests
//
// Captures decoded sensor words stamped with sys_ts into a linear buffer
// (block n at address n-1, no pop) and serves requests by 1-based block
// number with a data_ready handshake. One instance per photodiode.
//
// Optional feature macro: AUTO_FLUSH_EN
//    When defined, the buffer flushes itself after FLUSH_TICKS cycles without
//    a write, provided it holds blocks and no request is pending.
//
// Parameters:
//    DEPTH        blocks stored (1..255)
//    FLUSH_TICKS  idle cycles before auto-flush (AUTO_FLUSH_EN only)
//
// Ports:
//    clk_96MHz            in   system clock, rising edge
//    reset                in   synchronous, active-high
//    wr_en                in   strobe: store {wr_data, sys_ts}
//    wr_data[16:0]        in   decoded sensor word
//    sys_ts[23:0]         in   system timestamp sampled on wr_en
//    flush                in   strobe: discard all stored blocks
//    block_wanted_number  in   requested block, 1 = oldest, 0 = none
//    block_wanted[40:0]   out  {data, ts} of the requested block
//    data_ready           out  block_wanted valid for the current request
//    avl_blocks_nb[7:0]   out  blocks currently stored
//    overflow             out  sticky: a write was dropped while full
module sensor_block_store #(
   parameter int DEPTH       = 128,
   parameter int FLUSH_TICKS = 5000
) (
   input  logic        clk_96MHz,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [16:0] wr_data,
   input  logic [23:0] sys_ts,
   input  logic        flush,
   input  logic [7:0]  block_wanted_number,
   output logic [40:0] block_wanted,
   output logic        data_ready,
   output logic [7:0]  avl_blocks_nb,
   output logic        overflow
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0]  DEPTH_C = 8'(DEPTH);

   if (DEPTH < 1 || DEPTH > 255 || FLUSH_TICKS < 1) begin : g_param_check
      $error("sensor_block_store: DEPTH must be 1..255 and FLUSH_TICKS >= 1");
   end

   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_VALID} rstate_t;

   logic [40:0]   mem [DEPTH];
   logic [40:0]   rd_data;
   logic [7:0]    count;
   logic [7:0]    req_q;
   logic [7:0]    prev_q;
   logic          flush_all;
   logic          do_write;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          req_changed;
   logic          req_servable;
   rstate_t       state;
   rstate_t       state_n;
   logic          dr_n;
   logic [40:0]   bw_n;

`ifdef AUTO_FLUSH_EN
   localparam int          IW      = $clog2(FLUSH_TICKS + 1);
   localparam logic [IW-1:0] TICKS_C = IW'(FLUSH_TICKS);

   logic [IW-1:0] idle_cnt;
   logic          auto_flush;

   // Only flush when nobody is looking at the buffer.
   assign auto_flush = (idle_cnt == TICKS_C) && (count != 8'd0) && (req_q == 8'd0);
   assign flush_all  = flush | auto_flush;

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         idle_cnt <= '0;
      end else if (wr_en || flush_all) begin
         idle_cnt <= '0;
      end else if (idle_cnt != TICKS_C) begin
         idle_cnt <= idle_cnt + IW'(1);
      end
   end
`else
   assign flush_all = flush;
`endif

   // A flush in the same cycle as a write empties the buffer first, so the
   // write lands at address 0.
   assign do_write = wr_en && !reset && (flush_all || (count < DEPTH_C));
   assign wr_addr  = flush_all ? '0 : AW'(count);
   assign rd_addr  = AW'(req_q - 8'd1);

   always_ff @(posedge clk_96MHz) begin
      if (do_write) begin
         mem[wr_addr] <= {wr_data, sys_ts};
      end
      rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         count    <= 8'd0;
         overflow <= 1'b0;
      end else if (flush_all) begin
         count    <= wr_en ? 8'd1 : 8'd0;
         overflow <= 1'b0;
      end else if (wr_en) begin
         if (count < DEPTH_C) begin
            count <= count + 8'd1;
         end else begin
            overflow <= 1'b1;
         end
      end
   end

   assign avl_blocks_nb = count;

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         req_q  <= 8'd0;
         prev_q <= 8'd0;
      end else begin
         req_q  <= block_wanted_number;
         prev_q <= req_q;
      end
   end

   assign req_changed  = (req_q != prev_q);
   assign req_servable = (req_q != 8'd0) && (req_q <= count);

   // The memory read is issued unconditionally from req_q every cycle, so
   // entering R_FETCH means the read for req_q is already in flight. A
   // request that changes to another stored block re-enters R_FETCH directly,
   // keeping the same three-cycle latency as a request from idle.
   always_comb begin
      state_n = state;
      dr_n    = 1'b0;
      bw_n    = '0;
      case (state)
         R_IDLE: begin
            if (req_servable) begin
               state_n = R_FETCH;
            end
         end
         R_FETCH: begin
            if (!req_changed) begin
               dr_n    = 1'b1;
               bw_n    = rd_data;
               state_n = R_VALID;
            end else begin
               state_n = req_servable ? R_FETCH : R_IDLE;
            end
         end
         R_VALID: begin
            if (!req_changed) begin
               dr_n = data_ready;
               bw_n = block_wanted;
            end else begin
               state_n = req_servable ? R_FETCH : R_IDLE;
            end
         end
         default: begin
            state_n = R_IDLE;
         end
      endcase
      if (flush_all) begin
         state_n = R_IDLE;
         dr_n    = 1'b0;
         bw_n    = '0;
      end
   end

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         state        <= R_IDLE;
         data_ready   <= 1'b0;
         block_wanted <= '0;
      end else begin
         state        <= state_n;
         data_ready   <= dr_n;
         block_wanted <= bw_n;
      end
   end

endmodule

// File: tb/tb_sensor_block_store.sv
// tb/tb_sensor_block_store.sv - self-checking bench for sensor_block_store (DEPTH 128 and DEPTH 4)
module tb_sensor_block_store;

   localparam int FT = 20;

   logic        clk_96MHz = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [16:0] wr_data = '0;
   logic [23:0] sys_ts = '0;
   logic        flush = 1'b0;
   logic [7:0]  block_wanted_number = '0;

   logic [40:0] bw_b, bw_s;
   logic        dr_b, dr_s;
   logic [7:0]  avl_b, avl_s;
   logic        ovf_b, ovf_s;

   always #5 clk_96MHz = ~clk_96MHz;

   sensor_block_store #(.DEPTH(128), .FLUSH_TICKS(FT)) u_big (
      .clk_96MHz(clk_96MHz), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .sys_ts(sys_ts), .flush(flush), .block_wanted_number(block_wanted_number),
      .block_wanted(bw_b), .data_ready(dr_b), .avl_blocks_nb(avl_b), .overflow(ovf_b)
   );

   sensor_block_store #(.DEPTH(4), .FLUSH_TICKS(FT)) u_small (
      .clk_96MHz(clk_96MHz), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .sys_ts(sys_ts), .flush(flush), .block_wanted_number(block_wanted_number),
      .block_wanted(bw_s), .data_ready(dr_s), .avl_blocks_nb(avl_s), .overflow(ovf_s)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: stored blocks per instance plus the request/flush
   // history that decides when a block becomes visible. A block r is shown
   // in cycle t when the request r was present in cycles t-3 and t-2, block r
   // existed in cycle t-2, and no flush happened in cycles t-2 or t-1.
   int          dep [2] = '{128, 4};
   logic [40:0] mq [2][128];
   int          msz [2];
   bit          movf [2];
   int          idle_m [2];
   int          cnt_prev [2];
   bit          fl_prev [2];
   int          req_prev = 0;
   int          req_prev2 = 0;
   bit          e_dr [2];
   logic [40:0] e_bw [2];

   task automatic step(input bit w, input logic [16:0] d, input logic [23:0] ts,
                       input bit f, input logic [7:0] r, input bit rs);
      reset = rs; wr_en = w; wr_data = d; sys_ts = ts; flush = f; block_wanted_number = r;
      for (int k = 0; k < 2; k++) begin
         int cnt_now;
         bit au;
         bit fle;
         cnt_now = msz[k];
         au = 1'b0;
`ifdef AUTO_FLUSH_EN
         au = (idle_m[k] >= FT) && (msz[k] != 0) && (req_prev == 0);
`endif
         fle = f || au;
         if (rs) begin
            msz[k] = 0; movf[k] = 0;
         end else begin
            if (fle) begin
               msz[k] = 0; movf[k] = 0;
            end
            if (w) begin
               if (msz[k] < dep[k]) begin
                  mq[k][msz[k]] = {d, ts};
                  msz[k]++;
               end else begin
                  movf[k] = 1;
               end
            end
         end
         if (rs || w || fle) idle_m[k] = 0;
         else if (idle_m[k] < FT) idle_m[k]++;
         e_dr[k] = !rs && !fle && !fl_prev[k] && (req_prev == req_prev2) &&
                   (req_prev != 0) && (req_prev <= cnt_prev[k]);
         e_bw[k] = e_dr[k] ? mq[k][req_prev-1] : 41'd0;
         fl_prev[k]  = fle || rs;
         cnt_prev[k] = cnt_now;
      end
      req_prev2 = rs ? 0 : req_prev;
      req_prev  = rs ? 0 : int'(r);
      @(posedge clk_96MHz);
      #1;
      chk("b_avl", avl_b, msz[0]);
      chk("b_ovf", ovf_b, movf[0]);
      chk("b_dr",  dr_b,  e_dr[0]);
      chk("b_bw",  bw_b,  e_bw[0]);
      chk("s_avl", avl_s, msz[1]);
      chk("s_ovf", ovf_s, movf[1]);
      chk("s_dr",  dr_s,  e_dr[1]);
      chk("s_bw",  bw_s,  e_bw[1]);
   endtask

   typedef struct {
      bit          w;
      logic [16:0] d;
      logic [23:0] ts;
      bit          f;
      logic [7:0]  r;
      int          avl;
      bit          ovf;
      int          avl_s;
      bit          ovf_s;
      bit          dr;
      logic [40:0] bw;
   } vec_t;

   function automatic vec_t mk(bit w, logic [16:0] d, logic [23:0] ts, bit f, logic [7:0] r,
                               int avl, bit ovf, int avl_s, bit ovf_s, bit dr, logic [40:0] bw);
      vec_t v;
      v.w = w; v.d = d; v.ts = ts; v.f = f; v.r = r;
      v.avl = avl; v.ovf = ovf; v.avl_s = avl_s; v.ovf_s = ovf_s; v.dr = dr; v.bw = bw;
      return v;
   endfunction

   localparam logic [40:0] B1 = {17'h00011, 24'd100};
   localparam logic [40:0] B2 = {17'h00022, 24'd200};
   localparam logic [40:0] B5 = {17'h00055, 24'd500};
   localparam logic [40:0] BA = {17'h000AA, 24'h000123};

   vec_t tv[$];

   initial begin
      tv.push_back(mk(1, 17'h11, 24'd100, 0, 0, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(1, 17'h22, 24'd200, 0, 0, 2, 0, 2, 0, 0, 0));
      tv.push_back(mk(1, 17'h33, 24'd300, 0, 0, 3, 0, 3, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 2, 3, 0, 3, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 2, 3, 0, 3, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 2, 3, 0, 3, 0, 1, B2));
      for (int i = 0; i < 9; i++) tv.push_back(mk(0, 0, 0, 0, 2, 3, 0, 3, 0, 1, B2));
      tv.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 1, B2));
      tv.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 1, B1));
      tv.push_back(mk(0, 0, 0, 0, 0, 3, 0, 3, 0, 1, B1));
      tv.push_back(mk(0, 0, 0, 0, 0, 3, 0, 3, 0, 0, 0));
      for (int i = 0; i < 4; i++) tv.push_back(mk(0, 0, 0, 0, 5, 3, 0, 3, 0, 0, 0));
      tv.push_back(mk(1, 17'h44, 24'd400, 0, 5, 4, 0, 4, 0, 0, 0));
      tv.push_back(mk(1, 17'h55, 24'd500, 0, 5, 5, 0, 4, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 5, 5, 0, 4, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 5, 5, 0, 4, 1, 1, B5));
      tv.push_back(mk(0, 0, 0, 0, 0, 5, 0, 4, 1, 1, B5));
      tv.push_back(mk(0, 0, 0, 0, 0, 5, 0, 4, 1, 0, 0));
      tv.push_back(mk(1, 17'h66, 24'd600, 0, 0, 6, 0, 4, 1, 0, 0));
      tv.push_back(mk(1, 17'hAA, 24'h000123, 1, 0, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, BA));
      tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, BA));
      tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));

      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("reset_avl", avl_b, 0);
      chk("reset_dr",  dr_b,  0);
      chk("reset_bw",  bw_b,  0);
      chk("reset_ovf", ovf_b, 0);

      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].w, tv[i].d, tv[i].ts, tv[i].f, tv[i].r, 0);
         chk($sformatf("row%0d_avl", i),   avl_b, tv[i].avl);
         chk($sformatf("row%0d_ovf", i),   ovf_b, tv[i].ovf);
         chk($sformatf("row%0d_avl_s", i), avl_s, tv[i].avl_s);
         chk($sformatf("row%0d_ovf_s", i), ovf_s, tv[i].ovf_s);
         chk($sformatf("row%0d_dr", i),    dr_b,  tv[i].dr);
         chk($sformatf("row%0d_bw", i),    bw_b,  tv[i].bw);
      end

      begin
         logic [7:0] r;
         r = 0;
         for (int i = 0; i < 3000; i++) begin
            bit w, f, rs;
            if ($urandom_range(0, 5) == 0) r = 8'($urandom_range(0, 12));
            w  = ($urandom_range(0, 9) < 4);
            f  = ($urandom_range(0, 49) == 0);
            rs = ($urandom_range(0, 499) == 0);
            step(w, 17'($urandom), 24'($urandom), f, r, rs);
         end
      end

      step(0, 0, 0, 1, 0, 0);
      step(1, 17'h101, 24'd11, 0, 0, 0);
      step(1, 17'h102, 24'd12, 0, 0, 0);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 0);
      chk("idle15_avl", avl_b, 2);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
`ifdef AUTO_FLUSH_EN
      chk("idle25_avl", avl_b, 0);
`else
      chk("idle25_avl", avl_b, 2);
      step(0, 0, 0, 1, 0, 0);
`endif
      step(1, 17'h201, 24'd21, 0, 1, 0);
      step(1, 17'h202, 24'd22, 0, 1, 0);
      for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1, 0);
      chk("held_avl", avl_b, 2);
      chk("held_dr",  dr_b,  1);
      chk("held_bw",  bw_b,  {17'h201, 24'd21});
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
`ifdef AUTO_FLUSH_EN
      chk("release_avl", avl_b, 0);
`else
      chk("release_avl", avl_b, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
